// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch flush, memory-busy freeze.
// Zero latency (outputs combinational from state+inputs); freezes all enables while memory is busy.
module hazard_stall_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rd_i,
    input  logic [4:0]       IFID_Rs1_i,
    input  logic [4:0]       IFID_Rs2_i,
    input  logic             Branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             NoOp_o,
    output logic             Flush_o,
    output logic             PipeEn_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_err_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;

    logic hz;
    logic mem_busy;
    logic wait_last;
    logic wait_exit;
    logic timeout;
    logic run_rules;
    logic stall_evt;

    assign hz = IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
                ((IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i));

    assign mem_busy  = dmem_req_i && !dmem_ack_i;
    assign wait_last = (wait_cnt == WAIT_LAST);
    assign wait_exit = (state == S_MEM_WAIT) && (dmem_ack_i || wait_last);
    // A coinciding ack wins over the timeout: the access did complete.
    assign timeout   = (state == S_MEM_WAIT) && !dmem_ack_i && wait_last;

    // Cycles in which the normal hazard/branch rules drive the pipeline.
    assign run_rules = ((state == S_RUN) && !mem_busy) || wait_exit;

    assign stall_evt = (state == S_MEM_WAIT) || (run_rules && hz);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_i) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (mem_busy) state_nxt = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (wait_exit) state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        PCWrite_o   = 1'b0;
        IFIDWrite_o = 1'b0;
        NoOp_o      = 1'b0;
        Flush_o     = 1'b0;
        PipeEn_o    = 1'b0;
        if (state == S_IDLE) begin
            NoOp_o = 1'b1;
        end else if (run_rules) begin
            if (hz) begin
                NoOp_o   = 1'b1;
                PipeEn_o = 1'b1;
            end else begin
                PCWrite_o   = 1'b1;
                IFIDWrite_o = 1'b1;
                PipeEn_o    = 1'b1;
                Flush_o     = Branch_taken_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= 8'd0;
        end else if ((state == S_MEM_WAIT) && !wait_exit) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            mem_err_o   <= 1'b0;
        end else begin
            if (stall_evt && (stall_cnt_o != CNT_MAX)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (Flush_o && (flush_cnt_o != CNT_MAX))   flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            if (timeout) mem_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed vector table, hand-written corner sequences,
// then randomized traffic against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 4;
    localparam int TMO   = 4;
    localparam int SAT   = 15;

    logic       clk = 1'b0;
    logic       rst_n, start, mrd, br, req, ack;
    logic [4:0] rd, rs1, rs2;
    logic       pc_we, ifid_we, noop, flush, pipe_en, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .IDEX_MemRead_i(mrd), .IDEX_Rd_i(rd), .IFID_Rs1_i(rs1), .IFID_Rs2_i(rs2),
        .Branch_taken_i(br), .dmem_req_i(req), .dmem_ack_i(ack),
        .PCWrite_o(pc_we), .IFIDWrite_o(ifid_we), .NoOp_o(noop), .Flush_o(flush),
        .PipeEn_o(pipe_en), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
        .mem_err_o(mem_err)
    );

    typedef struct {
        logic       rst_n, start, mrd;
        logic [4:0] rd, rs1, rs2;
        logic       br, req, ack;
        logic       pc, ifid, noop, fl, pe;
        int         sc, fc;
        logic       err;
    } vec_t;

    function automatic vec_t mk(input logic r, s, m, input int d, a, b,
                                input logic bt, q, k,
                                input logic p, i, n, f, e, input int sc, fc, input logic er);
        vec_t v;
        v.rst_n = r; v.start = s; v.mrd = m;
        v.rd = 5'(d); v.rs1 = 5'(a); v.rs2 = 5'(b);
        v.br = bt; v.req = q; v.ack = k;
        v.pc = p; v.ifid = i; v.noop = n; v.fl = f; v.pe = e;
        v.sc = sc; v.fc = fc; v.err = er;
        return v;
    endfunction

    task automatic drive(input logic r, s, m, input logic [4:0] d, a, b, input logic bt, q, k);
        rst_n = r; start = s; mrd = m; rd = d; rs1 = a; rs2 = b; br = bt; req = q; ack = k;
    endtask

    task automatic compare(input string name, input logic [13:0] exp_v);
        logic [13:0] act_v;
        act_v = {pc_we, ifid_we, noop, flush, pipe_en, stall_cnt, flush_cnt, mem_err};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got pc/ifid/noop/fl/pe=%b sc=%0d fc=%0d err=%b, want pc/ifid/noop/fl/pe=%b sc=%0d fc=%0d err=%b",
                     name, act_v[13:9], act_v[8:5], act_v[4:1], act_v[0],
                     exp_v[13:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        @(negedge clk);
        drive(v.rst_n, v.start, v.mrd, v.rd, v.rs1, v.rs2, v.br, v.req, v.ack);
        #1;
        compare(name, {v.pc, v.ifid, v.noop, v.fl, v.pe, 4'(v.sc), 4'(v.fc), v.err});
    endtask

    vec_t tbl[$];

    // Behavioural model state for the random phase.
    int   m_mode;   // 0 idle, 1 running, 2 waiting on memory
    int   m_wait, m_stall, m_flush;
    logic m_err;

    initial begin
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        //            rst st mrd rd rs1 rs2 br req ack   pc if no fl pe  sc fc err
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0,  0, 0, 0)); // reset
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0,  0, 0, 0)); // idle
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0,  0, 0, 0)); // start
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1,  0, 0, 0)); // run
        tbl.push_back(mk(1, 0, 1, 5, 1, 5, 0, 0, 0,  0, 0, 1, 0, 1,  0, 0, 0)); // hz rs2
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1,  1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1,  1, 0, 0)); // rd=0
        tbl.push_back(mk(1, 0, 1, 7, 7, 2, 1, 0, 0,  0, 0, 1, 0, 1,  1, 0, 0)); // hz+br
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0, 1, 1,  2, 0, 0)); // flush
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1,  2, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  2, 1, 0)); // mem req
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  2, 1, 0)); // wait 0
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  3, 1, 0)); // wait 1
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1,  1, 1, 0, 0, 1,  4, 1, 0)); // ack exit
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1,  5, 1, 0));
        tbl.push_back(mk(1, 0, 1, 3, 3, 0, 0, 1, 1,  0, 0, 1, 0, 1,  5, 1, 0)); // req+ack, hz rs1
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1,  6, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  6, 1, 0)); // timeout run
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  6, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  7, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  8, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 1,  9, 1, 0)); // timeout exit
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 10, 1, 1)); // err set, start ignored
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 10, 1, 1)); // err sticky

        repeat (2) @(negedge clk);
        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

        // Stall counter saturation: five stalls reach 15, further stalls hold it.
        for (int i = 0; i < 7; i++)
            apply($sformatf("sat%0d", i),
                  mk(1, 0, 1, 9, 0, 9, 0, 0, 0,  0, 0, 1, 0, 1, (10 + i > SAT) ? SAT : 10 + i, 1, 1));
        apply("sat_hold", mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, SAT, 1, 1));

        // Reset in the middle of a memory wait.
        apply("mw_req",   mk(1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, SAT, 1, 1));
        apply("mw_wait",  mk(1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, SAT, 1, 1));
        apply("mw_reset", mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0,   0, 0, 0));
        apply("mw_idle",  mk(1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0,   0, 0, 0));

        // Randomized traffic against the behavioural model.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic h, follow, e_pc, e_if, e_no, e_fl, e_pe, stall_ev;
            logic [13:0] exp_v;
            @(negedge clk);
            drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0);
            #1;
            if (!rst_n) begin
                m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
            end
            h = mrd && (rd != 0) && (rd == rs1 || rd == rs2);
            {e_pc, e_if, e_no, e_fl, e_pe} = 5'b00000;
            follow = 1'b0;
            stall_ev = 1'b0;
            if (m_mode == 0) begin
                e_no = 1'b1;
            end else if (m_mode == 1) begin
                follow = !(req && !ack);
            end else begin
                stall_ev = 1'b1;
                follow = ack || (m_wait == TMO - 1);
            end
            if (follow) begin
                if (h) begin
                    e_no = 1'b1; e_pe = 1'b1; stall_ev = 1'b1;
                end else begin
                    e_pc = 1'b1; e_if = 1'b1; e_pe = 1'b1; e_fl = br;
                end
            end
            exp_v = {e_pc, e_if, e_no, e_fl, e_pe, 4'(m_stall), 4'(m_flush), m_err};
            compare($sformatf("rand%0d", cyc), exp_v);
            if (rst_n) begin
                if (stall_ev && m_stall < SAT) m_stall++;
                if (e_fl && m_flush < SAT) m_flush++;
                case (m_mode)
                    0: if (start) m_mode = 1;
                    1: if (req && !ack) begin m_mode = 2; m_wait = 0; end
                    default: begin
                        if (follow) begin
                            if (!ack) m_err = 1'b1;
                            m_mode = 1;
                            m_wait = 0;
                        end else begin
                            m_wait++;
                        end
                    end
                endcase
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
